// File: rtl/weight_fifo_loader.sv
// Weight FIFO read-side loader: pops one weight matrix into a shadow register
// and streams it row by row (highest row first) to the PE array.
module weight_fifo_loader #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         fifo_wr,
  output logic                                         fifo_rd_en,
  input  logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data,
  input  logic                                         load_req,
  output logic [WEIGHT_BW*MATRIX_SIZE-1:0]             w_row_data,
  output logic [$clog2(NUM_PE_ROWS)-1:0]               w_row_idx,
  output logic                                         w_row_valid,
  input  logic                                         w_row_ready,
  output logic                                         w_row_last,
  output logic                                         load_busy,
  output logic                                         load_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]              occupancy
);

  localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE;
  localparam int IDX_W = $clog2(NUM_PE_ROWS);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               pending;
  logic [ROW_W-1:0]   shadow [NUM_PE_ROWS];
  logic [IDX_W-1:0]   idx_dec;

  assign load_busy = (state != S_IDLE);
  assign idx_dec   = w_row_idx - 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The read is held off while fifo_wr is high so the FIFO never sees a
  // simultaneous read and write.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending && (occupancy != '0) && !fifo_wr) begin
          fifo_rd_en = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT:  state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_row_valid && w_row_ready && (w_row_idx == '0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
    end else if (load_req) begin
      pending <= 1'b1;
    end else if (fifo_rd_en) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else if (fifo_rd_en) begin
      occupancy <= occupancy - 1'b1;
    end else if (fifo_wr && (occupancy < OCC_W'(FIFO_DEPTH))) begin
      occupancy <= occupancy + 1'b1;
    end
  end

  // The first row is loaded straight from fifo_data so it is valid on the
  // first SHIFT cycle; later rows come from the shadow copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NUM_PE_ROWS; r++) begin
        shadow[r] <= '0;
      end
      w_row_data  <= '0;
      w_row_idx   <= '0;
      w_row_valid <= 1'b0;
      w_row_last  <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_WAIT: begin
          for (int unsigned r = 0; r < NUM_PE_ROWS; r++) begin
            shadow[r] <= fifo_data[r*ROW_W +: ROW_W];
          end
          w_row_data  <= fifo_data[(NUM_PE_ROWS-1)*ROW_W +: ROW_W];
          w_row_idx   <= IDX_W'(NUM_PE_ROWS - 1);
          w_row_valid <= 1'b1;
          w_row_last  <= (NUM_PE_ROWS == 1);
        end
        S_SHIFT: begin
          if (w_row_ready) begin
            if (w_row_idx == '0) begin
              w_row_valid <= 1'b0;
              w_row_last  <= 1'b0;
              load_done   <= 1'b1;
            end else begin
              w_row_idx  <= idx_dec;
              w_row_data <= shadow[idx_dec];
              w_row_last <= (idx_dec == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Scoreboard bench for weight_fifo_loader with a behavioural weight FIFO.
module tb_weight_fifo_loader;

  localparam int WBW   = 8;
  localparam int ROWS  = 8;
  localparam int MSZ   = 8;
  localparam int DEPTH = 4;
  localparam int ROW_W = WBW * MSZ;
  localparam int MAT_W = ROW_W * ROWS;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               fifo_wr = 1'b0;
  logic               fifo_rd_en;
  logic [MAT_W-1:0]   fifo_data;
  logic               load_req = 1'b0;
  logic [ROW_W-1:0]   w_row_data;
  logic [2:0]         w_row_idx;
  logic               w_row_valid;
  logic               w_row_ready = 1'b1;
  logic               w_row_last;
  logic               load_busy;
  logic               load_done;
  logic [2:0]         occupancy;

  weight_fifo_loader #(
    .WEIGHT_BW   (WBW),
    .NUM_PE_ROWS (ROWS),
    .MATRIX_SIZE (MSZ),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fifo_wr     (fifo_wr),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .load_req    (load_req),
    .w_row_data  (w_row_data),
    .w_row_idx   (w_row_idx),
    .w_row_valid (w_row_valid),
    .w_row_ready (w_row_ready),
    .w_row_last  (w_row_last),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  idx;
    logic        last;
  } row_t;

  row_t        sb[$];
  logic [7:0]  fq[$];
  logic [7:0]  wr_seed = 8'h00;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        done_exp = 1'b0;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_data;
  logic [2:0]  prev_idx;
  row_t        mon_e;

  function automatic logic [63:0] row_of(input logic [7:0] seed, input int i);
    logic [63:0] r;
    logic [7:0]  b;
    b = seed + 8'(i);
    for (int k = 0; k < MSZ; k++) r[k*8 +: 8] = b;
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] mat_of(input logic [7:0] seed);
    logic [MAT_W-1:0] m;
    for (int r = 0; r < ROWS; r++) m[r*ROW_W +: ROW_W] = row_of(seed, r);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input logic [7:0] seed);
    row_t e;
    for (int i = ROWS - 1; i >= 0; i--) begin
      e.data = row_of(seed, i);
      e.idx  = 3'(i);
      e.last = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic write1(input logic [7:0] seed);
    fifo_wr = 1'b1;
    wr_seed = seed;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      @(negedge clk);
      if (load_done) found = 1'b1;
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, 64'(w_row_valid), 64'd0);
    chk({nm, "_data"},  64'(w_row_data),  64'd0);
    chk({nm, "_idx"},   64'(w_row_idx),   64'd0);
    chk({nm, "_last"},  64'(w_row_last),  64'd0);
    chk({nm, "_done"},  64'(load_done),   64'd0);
    chk({nm, "_busy"},  64'(load_busy),   64'd0);
    chk({nm, "_rd"},    64'(fifo_rd_en),  64'd0);
    chk({nm, "_occ"},   64'(occupancy),   64'd0);
  endtask

  // behavioural FIFO: registered data_out, drops writes when full
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      fifo_data <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data <= mat_of(fq.pop_front());
      if (fifo_wr && fq.size() < DEPTH) fq.push_back(wr_seed);
    end
  end

  always @(posedge clk) cyc++;

  // monitor: pops scoreboard on every row handshake, checks hold and done
  always @(negedge clk) begin
    if (rstn) begin
      if (done_exp || load_done) chk("load_done", 64'(load_done), 64'(done_exp));
      done_exp = 1'b0;
      if (w_row_valid) begin
        if (hold_prev) begin
          chk("hold_data", w_row_data, prev_data);
          chk("hold_idx", 64'(w_row_idx), 64'(prev_idx));
        end
        if (w_row_ready) begin
          if (sb.size() == 0) begin
            chk("row_unexpected", 64'(w_row_idx), 64'hffff);
          end else begin
            mon_e = sb.pop_front();
            chk("row_data", w_row_data, mon_e.data);
            chk("row_idx", 64'(w_row_idx), 64'(mon_e.idx));
            chk("row_last", 64'(w_row_last), 64'(mon_e.last));
            if (mon_e.last) done_exp = 1'b1;
          end
        end
      end
      hold_prev = w_row_valid && !w_row_ready;
      prev_data = w_row_data;
      prev_idx  = w_row_idx;
    end else begin
      done_exp  = 1'b0;
      hold_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   n;
    logic got;
    logic bad;

    // reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    // 1: single matrix, ready high, latency
    write1(8'h01);
    @(negedge clk);
    chk("t1_occ1", 64'(occupancy), 64'd1);
    step();
    expect_load(8'h01);
    load_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    chk("t1_rd_T", 64'(fifo_rd_en), 64'd0);
    step();
    load_req = 1'b0;
    @(negedge clk);
    chk("t1_rd_T1", 64'(fifo_rd_en), 64'd1);
    chk("t1_busy_T1", 64'(load_busy), 64'd0);
    step();
    @(negedge clk);
    chk("t1_occ0", 64'(occupancy), 64'd0);
    chk("t1_busy_T2", 64'(load_busy), 64'd1);
    chk("t1_rd_T2", 64'(fifo_rd_en), 64'd0);
    wait_done("t1_done_seen");
    chk("t1_done_lat", 64'(cyc - t0), 64'(3 + ROWS));

    // 2: request with empty FIFO, write arrives later
    step();
    expect_load(8'h10);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fifo_rd_en || load_busy) bad = 1'b1;
      step();
    end
    chk("t2_no_early_rd", 64'(bad), 64'd0);
    fifo_wr = 1'b1;
    wr_seed = 8'h10;
    @(negedge clk);
    chk("t2_rd_on_wr", 64'(fifo_rd_en), 64'd0);
    step();
    fifo_wr = 1'b0;
    @(negedge clk);
    chk("t2_rd_after_wr", 64'(fifo_rd_en), 64'd1);
    wait_done("t2_done_seen");

    // 3: read deferred while fifo_wr is high
    step();
    write1(8'h20);
    expect_load(8'h20);
    load_req = 1'b1;
    fifo_wr  = 1'b1;
    wr_seed  = 8'h30;
    @(negedge clk);
    chk("t3_rd_c0", 64'(fifo_rd_en), 64'd0);
    step();
    load_req = 1'b0;
    wr_seed  = 8'h31;
    @(negedge clk);
    chk("t3_rd_c1", 64'(fifo_rd_en), 64'd0);
    step();
    wr_seed = 8'h32;
    @(negedge clk);
    chk("t3_rd_c2", 64'(fifo_rd_en), 64'd0);
    chk("t3_occ3", 64'(occupancy), 64'd3);
    step();
    fifo_wr = 1'b0;
    @(negedge clk);
    chk("t3_occ4", 64'(occupancy), 64'd4);
    chk("t3_rd_c3", 64'(fifo_rd_en), 64'd1);
    step();
    @(negedge clk);
    chk("t3_occ_after", 64'(occupancy), 64'd3);
    wait_done("t3_done_seen");

    // 4: ready toggling during SHIFT, starting low
    step();
    w_row_ready = 1'b0;
    expect_load(8'h30);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (w_row_valid) got = 1'b1;
      else step();
    end
    chk("t4_valid_seen", 64'(got), 64'd1);
    n = 0;
    while (got && w_row_valid && n < 40) begin
      n++;
      step();
      w_row_ready = ~w_row_ready;
      @(negedge clk);
    end
    chk("t4_shift_cycles", 64'(n), 64'd16);
    chk("t4_done", 64'(load_done), 64'd1);
    step();
    w_row_ready = 1'b1;

    // reset between groups empties both FIFO and tracker
    rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    check_zero("mid_reset");
    step();
    rstn = 1'b1;

    // 5: saturation, back-to-back requests, request while busy
    for (int s = 0; s < 5; s++) write1(8'h50 + 8'(s * 16));
    @(negedge clk);
    chk("t5_occ_sat", 64'(occupancy), 64'd4);
    step();
    expect_load(8'h50);
    expect_load(8'h60);
    load_req = 1'b1;
    step();
    @(negedge clk);
    chk("t5_rd_b2b", 64'(fifo_rd_en), 64'd1);
    step();
    load_req = 1'b0;
    wait_done("t5_done1");
    step();
    @(negedge clk);
    chk("t5_rd_second", 64'(fifo_rd_en), 64'd1);
    step();
    expect_load(8'h70);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    wait_done("t5_done2");
    chk("t5_occ_2", 64'(occupancy), 64'd2);
    wait_done("t5_done3");
    chk("t5_occ_1", 64'(occupancy), 64'd1);

    // 6: asynchronous reset mid-SHIFT at idx 4
    step();
    expect_load(8'h80);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (w_row_valid && w_row_idx == 3'd4) got = 1'b1;
      else step();
    end
    chk("t6_idx4_seen", 64'(got), 64'd1);
    #2 rstn = 1'b0;
    #1;
    sb.delete();
    check_zero("t6_async");
    repeat (3) step();
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (load_done || occupancy != 3'd0 || w_row_valid) bad = 1'b1;
      step();
    end
    chk("t6_quiet_after", 64'(bad), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
